// File: rtl/iot_sensor_pkg.sv
// Shared definitions for the IoT sensor controller's SPI motion-sensor path:
// register addresses, the SPI command byte layout and the WHO_AM_I identity value.
package iot_sensor_pkg;

    localparam logic [7:0] SPI_WHO_AM_I  = 8'h42;

    localparam logic [6:0] ADDR_WHO_AM_I = 7'h0F;
    localparam logic [6:0] ADDR_CTRL     = 7'h20;
    localparam logic [6:0] ADDR_SCRATCH  = 7'h21;
    localparam logic [6:0] ADDR_STATUS   = 7'h27;
    localparam logic [6:0] ADDR_OUT_X_L  = 7'h28;
    localparam logic [6:0] ADDR_OUT_X_H  = 7'h29;
    localparam logic [6:0] ADDR_OUT_Y_L  = 7'h2A;
    localparam logic [6:0] ADDR_OUT_Y_H  = 7'h2B;
    localparam logic [6:0] ADDR_OUT_Z_L  = 7'h2C;
    localparam logic [6:0] ADDR_OUT_Z_H  = 7'h2D;

    // Command byte as received on MOSI: bit 7 = read, bits 6:0 = address.
    typedef struct packed {
        logic       rd;
        logic [6:0] addr;
    } spi_cmd_t;

    // Only CTRL and SCRATCH accept writes; everything else drops them silently.
    function automatic logic is_writable(logic [6:0] addr);
        return (addr == ADDR_CTRL) || (addr == ADDR_SCRATCH);
    endfunction

endpackage

// File: rtl/motion_spi_regfile.sv
// Register file of the motion-sensor SPI responder: address decode, read mux,
// write commit, acceleration shadow copy and STATUS latch.
// Ports:
//   spi_clk, rst_n      rising-edge clock and synchronous active-low reset
//   rd_addr_i/rd_data_o combinational read port
//   wr_en_i/wr_addr_i/wr_data_i  write request (dropped for read-only/unmapped)
//   snap_i              capture live accel/sample_valid into shadow/STATUS
//   accel_*_i, sample_valid_i    live sensor inputs
//   ctrl_reg_o          CTRL register; wr_strobe_o pulses on committed writes
module motion_spi_regfile
    import iot_sensor_pkg::*;
#(
    parameter logic [7:0] WHO_AM_I_VAL = SPI_WHO_AM_I
) (
    input  logic        spi_clk,
    input  logic        rst_n,
    input  logic [6:0]  rd_addr_i,
    output logic [7:0]  rd_data_o,
    input  logic        wr_en_i,
    input  logic [6:0]  wr_addr_i,
    input  logic [7:0]  wr_data_i,
    input  logic        snap_i,
    input  logic [15:0] accel_x_i,
    input  logic [15:0] accel_y_i,
    input  logic [15:0] accel_z_i,
    input  logic        sample_valid_i,
    output logic [7:0]  ctrl_reg_o,
    output logic        wr_strobe_o
);

    logic [7:0]  ctrl_q, ctrl_d;
    logic [7:0]  scratch_q, scratch_d;
    logic [47:0] shadow_q, shadow_d;
    logic        status_q, status_d;
    logic        wr_strobe_q, wr_strobe_d;

    logic        wr_ok;
    logic [47:0] snap_src;
    logic        status_src;

    always_comb begin
        wr_ok       = wr_en_i && is_writable(wr_addr_i);
        ctrl_d      = ctrl_q;
        scratch_d   = scratch_q;
        if (wr_ok && (wr_addr_i == ADDR_CTRL))    ctrl_d    = wr_data_i;
        if (wr_ok && (wr_addr_i == ADDR_SCRATCH)) scratch_d = wr_data_i;
        wr_strobe_d = wr_ok;

        shadow_d    = snap_i ? {accel_z_i, accel_y_i, accel_x_i} : shadow_q;
        status_d    = snap_i ? sample_valid_i : status_q;

        // The first read byte loads on the same edge that takes the snapshot,
        // so bypass the shadow then to keep the burst coherent.
        snap_src    = snap_i ? {accel_z_i, accel_y_i, accel_x_i} : shadow_q;
        status_src  = snap_i ? sample_valid_i : status_q;

        case (rd_addr_i)
            ADDR_WHO_AM_I: rd_data_o = WHO_AM_I_VAL;
            ADDR_CTRL:     rd_data_o = ctrl_q;
            ADDR_SCRATCH:  rd_data_o = scratch_q;
            ADDR_STATUS:   rd_data_o = {7'd0, status_src};
            ADDR_OUT_X_L:  rd_data_o = snap_src[7:0];
            ADDR_OUT_X_H:  rd_data_o = snap_src[15:8];
            ADDR_OUT_Y_L:  rd_data_o = snap_src[23:16];
            ADDR_OUT_Y_H:  rd_data_o = snap_src[31:24];
            ADDR_OUT_Z_L:  rd_data_o = snap_src[39:32];
            ADDR_OUT_Z_H:  rd_data_o = snap_src[47:40];
            default:       rd_data_o = 8'h00;
        endcase
    end

    always_ff @(posedge spi_clk) begin
        if (!rst_n) begin
            ctrl_q      <= 8'h00;
            scratch_q   <= 8'h00;
            shadow_q    <= 48'd0;
            status_q    <= 1'b0;
            wr_strobe_q <= 1'b0;
        end else begin
            ctrl_q      <= ctrl_d;
            scratch_q   <= scratch_d;
            shadow_q    <= shadow_d;
            status_q    <= status_d;
            wr_strobe_q <= wr_strobe_d;
        end
    end

    assign ctrl_reg_o  = ctrl_q;
    assign wr_strobe_o = wr_strobe_q;

endmodule

// File: rtl/motion_sensor_spi_slave.sv
// SPI mode-0 responder modelling the motion sensor on the controller's SPI link.
// Byte 0 of a frame is the command (bit 7 read, bits 6:0 address); further bytes
// are data. Holds the shifters, bit counter, abort flag and MISO register.
// Build option: MOTION_SPI_AUTOINC_EN enables address auto-increment in bursts.
// Ports:
//   spi_clk, rst_n       SCLK (both edges used), synchronous active-low reset
//   spi_cs               active-low select; high asynchronously clears frame state
//   spi_mosi, spi_miso   serial data in (rising edge) / out (falling edge)
//   accel_x/y/z, sample_valid  live sensor inputs
//   ctrl_reg, wr_strobe  CTRL register value and committed-write pulse
module motion_sensor_spi_slave
    import iot_sensor_pkg::*;
#(
    parameter logic [7:0] WHO_AM_I_VAL = SPI_WHO_AM_I
) (
    input  logic        spi_clk,
    input  logic        rst_n,
    input  logic        spi_cs,
    input  logic        spi_mosi,
    output logic        spi_miso,
    input  logic [15:0] accel_x,
    input  logic [15:0] accel_y,
    input  logic [15:0] accel_z,
    input  logic        sample_valid,
    output logic [7:0]  ctrl_reg,
    output logic        wr_strobe
);

    logic [3:0] bit_cnt_q, bit_cnt_d;
    logic [6:0] rx_q, rx_d;
    logic [7:0] tx_q, tx_d;
    spi_cmd_t   cmd_q, cmd_d;
    logic       abort_q;
    logic       miso_q, miso_d;

    logic       cmd_edge;
    logic       byte_edge;
    logic [7:0] rx_byte;
    logic [6:0] next_addr;
    logic [6:0] rd_addr;
    logic [7:0] rd_data;
    logic       snap;
    logic       wr_en;

    always_comb begin
        // bit_cnt_q is the number of rising edges already seen in this frame;
        // it parks in 8..15 for data bytes. Both are 0 while spi_cs is high.
        cmd_edge  = (bit_cnt_q == 4'd7);
        byte_edge = (bit_cnt_q == 4'd15);
        rx_byte   = {rx_q, spi_mosi};

`ifdef MOTION_SPI_AUTOINC_EN
        next_addr = cmd_q.addr + 7'd1;
`else
        next_addr = cmd_q.addr;
`endif

        snap      = !abort_q && cmd_edge;
        wr_en     = !abort_q && byte_edge && !cmd_q.rd;
        rd_addr   = cmd_edge ? rx_byte[6:0] : next_addr;

        bit_cnt_d = byte_edge ? 4'd8 : bit_cnt_q + 4'd1;
        rx_d      = rx_byte[6:0];
        cmd_d     = cmd_q;
        if (cmd_edge)  cmd_d      = spi_cmd_t'(rx_byte);
        if (byte_edge) cmd_d.addr = next_addr;

        tx_d      = {tx_q[6:0], 1'b0};
        if ((cmd_edge && rx_byte[7]) || (byte_edge && cmd_q.rd)) tx_d = rd_data;

        miso_d    = abort_q ? 1'b0 : tx_q[7];
    end

    // Frame state: spi_cs high clears everything including the abort flag; a
    // reset inside a frame aborts it until the next deselect.
    always_ff @(posedge spi_clk or posedge spi_cs) begin
        if (spi_cs) begin
            bit_cnt_q <= 4'd0;
            rx_q      <= 7'd0;
            tx_q      <= 8'd0;
            cmd_q     <= '0;
            abort_q   <= 1'b0;
        end else if (!rst_n) begin
            bit_cnt_q <= 4'd0;
            rx_q      <= 7'd0;
            tx_q      <= 8'd0;
            cmd_q     <= '0;
            abort_q   <= 1'b1;
        end else if (!abort_q) begin
            bit_cnt_q <= bit_cnt_d;
            rx_q      <= rx_d;
            tx_q      <= tx_d;
            cmd_q     <= cmd_d;
        end
    end

    always_ff @(negedge spi_clk or posedge spi_cs) begin
        if (spi_cs) begin
            miso_q <= 1'b0;
        end else begin
            miso_q <= miso_d;
        end
    end

    assign spi_miso = miso_q;

    motion_spi_regfile #(
        .WHO_AM_I_VAL(WHO_AM_I_VAL)
    ) u_regfile (
        .spi_clk        (spi_clk),
        .rst_n          (rst_n),
        .rd_addr_i      (rd_addr),
        .rd_data_o      (rd_data),
        .wr_en_i        (wr_en),
        .wr_addr_i      (cmd_q.addr),
        .wr_data_i      (rx_byte),
        .snap_i         (snap),
        .accel_x_i      (accel_x),
        .accel_y_i      (accel_y),
        .accel_z_i      (accel_z),
        .sample_valid_i (sample_valid),
        .ctrl_reg_o     (ctrl_reg),
        .wr_strobe_o    (wr_strobe)
    );

endmodule

// File: tb/tb_motion_sensor_spi_slave.sv
// Directed bench for motion_sensor_spi_slave acting as an SPI mode-0 master.
module tb_motion_sensor_spi_slave;

    logic        spi_clk = 1'b0;
    logic        rst_n;
    logic        spi_cs;
    logic        spi_mosi;
    logic        spi_miso;
    logic [15:0] accel_x, accel_y, accel_z;
    logic        sample_valid;
    logic [7:0]  ctrl_reg;
    logic        wr_strobe;

    int total = 0;
    int bad   = 0;
    int strobe_cnt = 0;

    motion_sensor_spi_slave dut (
        .spi_clk      (spi_clk),
        .rst_n        (rst_n),
        .spi_cs       (spi_cs),
        .spi_mosi     (spi_mosi),
        .spi_miso     (spi_miso),
        .accel_x      (accel_x),
        .accel_y      (accel_y),
        .accel_z      (accel_z),
        .sample_valid (sample_valid),
        .ctrl_reg     (ctrl_reg),
        .wr_strobe    (wr_strobe)
    );

    always #5 spi_clk = ~spi_clk;

    // Each strobe pulse spans exactly one falling edge.
    always @(negedge spi_clk) if (wr_strobe === 1'b1) strobe_cnt++;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Entered and left just after a falling edge (spi_clk low).
    task automatic xfer(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
        rx = 8'h00;
        for (int i = 7; i > 7 - nbits; i--) begin
            spi_mosi = tx[i];
            rx[i]    = spi_miso;
            @(posedge spi_clk);
            @(negedge spi_clk);
            #1;
        end
    endtask

    task automatic cs_low;
        @(negedge spi_clk);
        #1;
        spi_cs = 1'b0;
    endtask

    task automatic cs_high;
        spi_cs   = 1'b1;
        spi_mosi = 1'b0;
        repeat (2) @(negedge spi_clk);
        #1;
    endtask

    task automatic rd_frame(input logic [7:0] cmd, output logic [7:0] d);
        logic [7:0] junk;
        cs_low();
        xfer(cmd, 8, junk);
        xfer(8'h00, 8, d);
        cs_high();
    endtask

    task automatic wr_frame(input logic [7:0] cmd, input logic [7:0] d);
        logic [7:0] junk;
        cs_low();
        xfer(cmd, 8, junk);
        xfer(d, 8, junk);
        cs_high();
    endtask

    logic [7:0] rd, junk;
    logic [7:0] exp_burst [6];
    int         s0;
    logic       late_or;

    initial begin
        rst_n        = 1'b0;
        spi_cs       = 1'b1;
        spi_mosi     = 1'b0;
        accel_x      = 16'h0000;
        accel_y      = 16'h0000;
        accel_z      = 16'h0000;
        sample_valid = 1'b0;
        repeat (2) @(posedge spi_clk);
        @(negedge spi_clk);
        #1;
        check("reset_miso", {7'd0, spi_miso}, 8'h00);
        check("reset_ctrl", ctrl_reg, 8'h00);
        check("reset_strobe", {7'd0, wr_strobe}, 8'h00);
        rst_n = 1'b1;
        @(negedge spi_clk);
        #1;

        rd_frame(8'h8F, rd);
        check("who_am_i", rd, 8'h42);

        s0 = strobe_cnt;
        wr_frame(8'h20, 8'h5A);
        check("ctrl_after_write", ctrl_reg, 8'h5A);
        check("ctrl_write_strobe", 8'(strobe_cnt - s0), 8'd1);
        rd_frame(8'hA0, rd);
        check("ctrl_readback", rd, 8'h5A);

        // Burst read with the live inputs changing after the command byte.
        accel_x      = 16'h1234;
        accel_y      = 16'h5678;
        accel_z      = 16'h9ABC;
        sample_valid = 1'b1;
`ifdef MOTION_SPI_AUTOINC_EN
        exp_burst = '{8'h34, 8'h12, 8'h78, 8'h56, 8'hBC, 8'h9A};
`else
        exp_burst = '{8'h34, 8'h34, 8'h34, 8'h34, 8'h34, 8'h34};
`endif
        cs_low();
        xfer(8'hA8, 8, junk);
        accel_x = 16'hFFFF;
        accel_y = 16'hEEEE;
        accel_z = 16'hDDDD;
        for (int b = 0; b < 6; b++) begin
            xfer(8'h00, 8, rd);
            check($sformatf("burst_byte%0d", b), rd, exp_burst[b]);
        end
        cs_high();

        rd_frame(8'hA7, rd);
        check("status_valid", rd, 8'h01);
        sample_valid = 1'b0;
        rd_frame(8'hA7, rd);
        check("status_clear", rd, 8'h00);

        // SCRATCH write cut short after 12 bits.
        s0 = strobe_cnt;
        cs_low();
        xfer(8'h21, 8, junk);
        xfer(8'hF0, 4, junk);
        cs_high();
        check("partial_no_strobe", 8'(strobe_cnt - s0), 8'd0);
        rd_frame(8'hA1, rd);
        check("scratch_untouched", rd, 8'h00);
        wr_frame(8'h21, 8'hC3);
        rd_frame(8'hA1, rd);
        check("scratch_readback", rd, 8'hC3);

        rd_frame(8'h85, rd);
        check("unmapped_read", rd, 8'h00);
        s0 = strobe_cnt;
        wr_frame(8'h0F, 8'hFF);
        check("ro_write_no_strobe", 8'(strobe_cnt - s0), 8'd0);
        rd_frame(8'h8F, rd);
        check("who_am_i_after_write", rd, 8'h42);

        // Reset at rising edge 10 of a CTRL read (CTRL = 0x5A).
        late_or = 1'b0;
        cs_low();
        xfer(8'hA0, 8, junk);
        for (int i = 7; i >= 0; i--) begin
            spi_mosi = 1'b0;
            if (i == 6) begin
                check("abort_bit6_live", {7'd0, spi_miso}, 8'h01);
                rst_n = 1'b0;
            end
            if (i == 5) rst_n = 1'b1;
            if (i <= 5) late_or = late_or | spi_miso;
            @(posedge spi_clk);
            @(negedge spi_clk);
            #1;
        end
        late_or = late_or | spi_miso;
        check("abort_miso_low", {7'd0, late_or}, 8'h00);
        check("abort_ctrl_reset", ctrl_reg, 8'h00);
        cs_high();
        rd_frame(8'h8F, rd);
        check("who_am_i_after_abort", rd, 8'h42);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
